dataflow_node: RTL and testbench

DATAFLOW_NODE -- requirements
Module: dataflow_node

---
 rtl/dataflow_pkg.sv | 47 ++++
 rtl/node_fifo.sv | 56 +++++
 rtl/dataflow_node.sv | 120 ++++++++++++
 tb/tb_dataflow_node.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared opcodes and the operand-evaluation function
// used by every dataflow block.
package dataflow_pkg;

    typedef enum logic [2:0] {
        OP_PASS,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_ADDI,
        OP_SUBI,
        OP_MULI
    } op_e;

    localparam int MAX_W  = 64;
    localparam int MAX_IN = 3;

    typedef logic [MAX_W-1:0] word_t;

    function automatic bit op_is_fold(op_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL};
    endfunction

    // Evaluated at full width; callers truncate, which keeps the
    // result correct modulo 2^width for add, sub and mul alike.
    function automatic word_t op_eval(
        op_e   op,
        word_t a0,
        word_t a1,
        word_t a2,
        int    n,
        word_t imm
    );
        word_t r;
        case (op)
            OP_ADD:  r = a0 + a1 + ((n > 2) ? a2 : '0);
            OP_SUB:  r = a0 - a1 - ((n > 2) ? a2 : '0);
            OP_MUL:  r = a0 * a1 * ((n > 2) ? a2 : word_t'(1));
            OP_ADDI: r = a0 + imm;
            OP_SUBI: r = a0 - imm;
            OP_MULI: r = a0 * imm;
            default: r = a0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/node_fifo.sv
// Count-based synchronous result buffer with full/empty flags.
module node_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    function automatic logic [AW-1:0] bump(logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/dataflow_node.sv
// Dataflow node: collect operands, compute, buffer the result
// and fork it eagerly to every downstream consumer.
module dataflow_node
    import dataflow_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_IN     = 2,
    parameter int                    NUM_OUT    = 1,
    parameter int                    FIFO_DEPTH = 2,
    parameter op_e                   OP         = OP_ADD,
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic [NUM_IN-1:0]                 req_l,
    input  logic [NUM_IN-1:0]                 ack_l,
    input  logic [DATA_WIDTH*NUM_IN-1:0]      din,
    input  logic [NUM_OUT-1:0]                req_r,
    output logic [NUM_OUT-1:0]                ack_r,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

    if (NUM_IN < 1 || NUM_IN > MAX_IN) begin : g_bad_num_in
        $error("dataflow_node: NUM_IN must be 1..3");
    end
    if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
        $error("dataflow_node: NUM_OUT must be 1..8");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dataflow_node: FIFO_DEPTH must be a power of two");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_W) begin : g_bad_width
        $error("dataflow_node: DATA_WIDTH must be 1..64");
    end
    if (op_is_fold(OP) && NUM_IN == 1) begin : g_bad_fold
        $error("dataflow_node: binary op needs NUM_IN > 1");
    end
    if (!op_is_fold(OP) && NUM_IN > 1) begin : g_bad_unary
        $error("dataflow_node: unary/immediate op needs NUM_IN == 1");
    end

    logic [NUM_IN-1:0]     full_q;
    logic [DATA_WIDTH-1:0] slot_q [NUM_IN];
    word_t                 opnd   [MAX_IN];
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] head;
    logic                  fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [NUM_OUT-1:0]    sent_q;
    logic [NUM_OUT-1:0]    done;
    logic                  pop;

    // Fire is gated on the pre-pop count so a full buffer never overflows.
    assign fire = (&full_q) && !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            req_l  <= '0;
            for (int i = 0; i < NUM_IN; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (fire) begin
                    full_q[i] <= 1'b0;
                end else if (ack_l[i] && !full_q[i]) begin
                    full_q[i] <= 1'b1;
                    slot_q[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            req_l <= fire ? '1 : ~(full_q | ack_l);
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_IN; i++) opnd[i] = '0;
        for (int i = 0; i < NUM_IN; i++) opnd[i] = word_t'(slot_q[i]);
    end

    assign result = DATA_WIDTH'(op_eval(OP, opnd[0], opnd[1], opnd[2],
                                        NUM_IN, word_t'(IMMEDIATE)));

    node_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .wdata (result),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    assign ack_r = fifo_empty ? '0 : (req_r & ~sent_q);
    assign done  = sent_q | ack_r;
    assign pop   = !fifo_empty && (&done);
    assign dout  = fifo_empty ? '0 : head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q <= '0;
        end else if (pop) begin
            sent_q <= '0;
        end else begin
            sent_q <= done;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ack_chk
        a_ack_while_full: assert property (
            @(posedge clk) disable iff (!rst_n) !(ack_l[i] && full_q[i])
        );
    end

endmodule

// File: tb/tb_dataflow_node.sv
// Scoreboard bench: three node configurations driven with random
// handshakes and checked against a plain-arithmetic reference.
module tb_dataflow_node;
    import dataflow_pkg::*;

    localparam int NC = 3;

    function automatic int ni_of(int c);
        return (c == 0) ? 2 : (c == 1) ? 3 : 1;
    endfunction
    function automatic int no_of(int c);
        return (c == 0) ? 1 : (c == 1) ? 3 : 2;
    endfunction
    function automatic int dp_of(int c);
        return (c == 0) ? 4 : (c == 1) ? 2 : 1;
    endfunction
    function automatic op_e op_of(int c);
        return (c == 0) ? OP_ADD : (c == 1) ? OP_SUB : OP_ADDI;
    endfunction
    function automatic int unsigned imm_of(int c);
        return (c == 2) ? 32'd2 : 32'd0;
    endfunction

    logic            clk = 1'b0;
    logic [NC-1:0]   rst_n;
    int              cyc = 0;
    int              tests;
    int              fails;
    int unsigned     opq  [NC][3][$];
    int unsigned     expq [NC][8][$];
    int              gap_pct  [NC];
    int              drop_pct [NC];
    logic [7:0]      hold_lo  [NC];
    int              ndeliv   [NC][8];
    int              t_drv    [NC];
    int              t_ack    [NC];
    logic [8*NC-1:0]  m_reql;
    logic [8*NC-1:0]  m_ackr;
    logic [8*NC-1:0]  m_occ;
    logic [32*NC-1:0] m_dout;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cfg%0d: got 0x%0h expected 0x%0h",
                     name, c, act, exp);
        end
    endtask

    // Reference: fold left for binary ops, immediate applied to operand 0.
    function automatic int unsigned ref_eval(int c, int unsigned a [3]);
        int unsigned r;
        r = a[0];
        case (op_of(c))
            OP_ADD:  for (int i = 1; i < ni_of(c); i++) r = r + a[i];
            OP_SUB:  for (int i = 1; i < ni_of(c); i++) r = r - a[i];
            OP_MUL:  for (int i = 1; i < ni_of(c); i++) r = r * a[i];
            OP_ADDI: r = a[0] + imm_of(c);
            OP_SUBI: r = a[0] - imm_of(c);
            OP_MULI: r = a[0] * imm_of(c);
            default: r = a[0];
        endcase
        return r;
    endfunction

    task automatic send(input int c, input int unsigned a0,
                        input int unsigned a1, input int unsigned a2);
        int unsigned a [3];
        int unsigned r;
        a = '{a0, a1, a2};
        r = ref_eval(c, a);
        for (int i = 0; i < ni_of(c); i++) opq[c][i].push_back(a[i]);
        for (int j = 0; j < no_of(c); j++) expq[c][j].push_back(r);
    endtask

    function automatic int pending(int c);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) n += opq[c][i].size();
        for (int j = 0; j < 8; j++) n += expq[c][j].size();
        return n;
    endfunction

    task automatic drain(input int c, input int budget);
        int n;
        n = 0;
        while (pending(c) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", c, pending(c), 0);
        repeat (5) @(posedge clk);
    endtask

    for (genvar c = 0; c < NC; c++) begin : g_cfg
        localparam int NI = ni_of(c);
        localparam int NO = no_of(c);
        localparam int D  = dp_of(c);

        logic [NI-1:0]          req_l;
        logic [NI-1:0]          ack_l;
        logic [32*NI-1:0]       din;
        logic [NO-1:0]          req_r;
        logic [NO-1:0]          ack_r;
        logic [31:0]            dout;
        logic [$clog2(D+1)-1:0] occupancy;

        dataflow_node #(
            .DATA_WIDTH (32),
            .NUM_IN     (NI),
            .NUM_OUT    (NO),
            .FIFO_DEPTH (D),
            .OP         (op_of(c)),
            .IMMEDIATE  (32'(imm_of(c)))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[c]),
            .req_l     (req_l),
            .ack_l     (ack_l),
            .din       (din),
            .req_r     (req_r),
            .ack_r     (ack_r),
            .dout      (dout),
            .occupancy (occupancy)
        );

        assign m_reql[8*c +: 8]  = 8'(req_l);
        assign m_ackr[8*c +: 8]  = 8'(ack_r);
        assign m_occ[8*c +: 8]   = 8'(occupancy);
        assign m_dout[32*c +: 32] = dout;

        // Upstream producers and downstream consumers.
        initial begin
            ack_l = '0;
            din   = '0;
            req_r = '0;
            forever begin
                @(posedge clk);
                #1;
                for (int i = 0; i < NI; i++) begin
                    ack_l[i] = 1'b0;
                    if (rst_n[c] && req_l[i] && opq[c][i].size() > 0 &&
                        int'($urandom_range(99)) >= gap_pct[c]) begin
                        ack_l[i] = 1'b1;
                        din[32*i +: 32] = opq[c][i].pop_front();
                        if (i == 0 && t_drv[c] < 0) t_drv[c] = cyc;
                    end
                end
                for (int j = 0; j < NO; j++) begin
                    req_r[j] = !hold_lo[c][j] &&
                               (int'($urandom_range(99)) >= drop_pct[c]);
                end
            end
        end

        // Monitor: every ack_r pulse pops that output's expected stream.
        initial forever begin
            @(negedge clk);
            for (int j = 0; j < NO; j++) begin
                if (ack_r[j]) begin
                    ndeliv[c][j]++;
                    if (t_ack[c] < 0) t_ack[c] = cyc;
                    check($sformatf("ack_needs_req[%0d]", j), c, 32'(req_r[j]), 1);
                    if (expq[c][j].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_ack cfg%0d out%0d: dout 0x%0h with nothing expected",
                                 c, j, dout);
                    end else begin
                        check($sformatf("dout[%0d]", j), c, dout,
                              expq[c][j].pop_front());
                    end
                end
            end
        end
    end

    int b0, b1, b2, n;

    initial begin
        rst_n = '0;
        tests = 0;
        fails = 0;
        for (int c = 0; c < NC; c++) begin
            gap_pct[c]  = 0;
            drop_pct[c] = 0;
            hold_lo[c]  = '0;
            t_drv[c]    = -1;
            t_ack[c]    = -1;
            for (int j = 0; j < 8; j++) ndeliv[c][j] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check("rst_req_l", c, m_reql[8*c +: 8], 0);
            check("rst_ack_r", c, m_ackr[8*c +: 8], 0);
            check("rst_occupancy", c, m_occ[8*c +: 8], 0);
            check("rst_dout", c, m_dout[32*c +: 32], 0);
        end

        send(0, 3, 4, 0);
        send(0, 32'hFFFF_FFFF, 2, 0);
        send(1, 10, 3, 2);
        for (int v = 0; v < 100; v++) send(2, v, 0, 0);

        @(posedge clk);
        #2;
        rst_n = '1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            check("req_l_after_rst", c, m_reql[8*c +: 8], (1 << ni_of(c)) - 1);
        end
        for (int c = 0; c < NC; c++) drain(c, 1000);
        for (int c = 0; c < NC; c++) check("latency", c, t_ack[c] - t_drv[c], 2);

        // Operands of one set arriving on different cycles.
        gap_pct[1] = 60;
        send(1, 10, 3, 2);
        for (int k = 0; k < 20; k++) send(1, $urandom(), $urandom(), $urandom());
        drain(1, 2000);
        gap_pct[1] = 0;

        // One consumer stalled while the others see the head once.
        b0 = ndeliv[1][0];
        b1 = ndeliv[1][1];
        b2 = ndeliv[1][2];
        hold_lo[1] = 8'b0000_0010;
        for (int k = 0; k < 4; k++) send(1, $urandom(), $urandom(), $urandom());
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("hold_occupancy", 1, m_occ[15:8], 2);
        check("hold_req_l", 1, m_reql[15:8], 0);
        check("hold_out0", 1, ndeliv[1][0] - b0, 1);
        check("hold_out1", 1, ndeliv[1][1] - b1, 0);
        check("hold_out2", 1, ndeliv[1][2] - b2, 1);
        hold_lo[1] = '0;
        drain(1, 500);
        check("release_out0", 1, ndeliv[1][0] - b0, 4);
        check("release_out1", 1, ndeliv[1][1] - b1, 4);
        check("release_out2", 1, ndeliv[1][2] - b2, 4);

        // Reset with two buffered results and one partial operand.
        hold_lo[0] = 8'h01;
        send(0, $urandom(), $urandom(), 0);
        send(0, $urandom(), $urandom(), 0);
        n = 0;
        while (m_occ[7:0] != 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        opq[0][0].push_back(32'h1234);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_occupancy", 0, m_occ[7:0], 2);
        rst_n[0] = 1'b0;
        #1;
        check("async_rst_occupancy", 0, m_occ[7:0], 0);
        check("async_rst_ack_r", 0, m_ackr[7:0], 0);
        check("async_rst_dout", 0, m_dout[31:0], 0);
        check("async_rst_req_l", 0, m_reql[7:0], 0);
        for (int i = 0; i < 3; i++) opq[0][i].delete();
        for (int j = 0; j < 8; j++) expq[0][j].delete();
        hold_lo[0] = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n[0] = 1'b1;
        send(0, 5, 6, 0);
        drain(0, 200);

        // Random consumer dropout on every configuration.
        gap_pct[0]  = 20;
        drop_pct[0] = 30;
        for (int k = 0; k < 500; k++) send(0, $urandom(), $urandom(), 0);
        drain(0, 5000);
        gap_pct[2]  = 20;
        drop_pct[2] = 30;
        for (int k = 0; k < 300; k++) send(2, $urandom(), 0, 0);
        drain(2, 4000);
        gap_pct[1]  = 10;
        drop_pct[1] = 30;
        for (int k = 0; k < 5000; k++) send(1, $urandom(), $urandom(), $urandom());
        drain(1, 40000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
